operand_stage: RTL

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/mips_pkg.sv | 33 +++
 rtl/operand_stage_if.sv | 43 ++++
 rtl/regfile.sv | 33 +++
 rtl/operand_stage.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the operand stage: ALU function codes, the
// in2 source selector and a small immediate-extension helper.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    typedef enum logic [2:0] {
        ALU_SLL = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SRL = 3'd3,
        ALU_SRA = 3'd4,
        ALU_SUB = 3'd5,
        ALU_AND = 3'd6,
        ALU_XOR = 3'd7
    } alu_func_e;

    typedef enum logic [1:0] {
        SELB_REG   = 2'd0,
        SELB_SEXT  = 2'd1,
        SELB_ZEXT  = 2'd2,
        SELB_SHAMT = 2'd3
    } sel_b_e;

    // Widen a 16-bit immediate, replicating bit 15 when signExt is set
    function automatic logic [DATA_W-1:0] extendImm(input logic [15:0] imm,
                                                    input logic        signExt);
        return signExt ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Handshake and data bundle of the operand stage. The slave modport is the
// stage's own view; the master modport is the surrounding pipeline's view.
interface operand_stage_if;
    import mips_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [15:0]       imm16;
    logic [4:0]        shamt;
    logic [1:0]        sel_b;
    logic [2:0]        func;
    logic [ADDR_W-1:0] dest;
    logic              we;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [2:0]        alu_func;
    logic [ADDR_W-1:0] out_dest;
    logic              out_we;

    modport slave (
        input  in_valid, rs, rt, imm16, shamt, sel_b, func, dest, we,
        input  wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, alu_in1, alu_in2, alu_func, out_dest, out_we
    );

    modport master (
        output in_valid, rs, rt, imm16, shamt, sel_b, func, dest, we,
        output wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, alu_in1, alu_in2, alu_func, out_dest, out_we
    );

endinterface

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. Register 0 always reads zero and ignores writes.
module regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [ADDR_W-1:0] rdAddrA_i,
    input  logic [ADDR_W-1:0] rdAddrB_i,
    output logic [DATA_W-1:0] rdDataA_o,
    output logic [DATA_W-1:0] rdDataB_o
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    // Clear every register on reset; afterwards write any nonzero address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrEn_i && (wrAddr_i != '0)) begin
            regs_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdDataA_o = (rdAddrA_i == '0) ? '0 : regs_q[rdAddrA_i];
    assign rdDataB_o = (rdAddrB_i == '0) ? '0 : regs_q[rdAddrB_i];

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: reads the register file, selects the second ALU
// operand and holds the result in a single-entry pipeline register with a
// valid/ready handshake on both sides.
// Optional build macro OPERAND_BYPASS_EN forwards a same-cycle writeback
// into the captured operands; without it the pre-write value is captured.
module operand_stage
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    operand_stage_if.slave     bus
);

    logic [DATA_W-1:0] rfRsData;
    logic [DATA_W-1:0] rfRtData;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] in2Sel;
    logic              accept;

    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] aluIn1_q,   aluIn1_d;
    logic [DATA_W-1:0] aluIn2_q,   aluIn2_d;
    alu_func_e         aluFunc_q,  aluFunc_d;
    logic [ADDR_W-1:0] outDest_q,  outDest_d;
    logic              outWe_q,    outWe_d;

    regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wrEn_i    (bus.wb_en),
        .wrAddr_i  (bus.wb_addr),
        .wrData_i  (bus.wb_data),
        .rdAddrA_i (bus.rs),
        .rdAddrB_i (bus.rt),
        .rdDataA_o (rfRsData),
        .rdDataB_o (rfRtData)
    );

    assign bus.in_ready = !outValid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef OPERAND_BYPASS_EN
    // Forward a same-cycle writeback over the stale register-file value
    always_comb begin
        opA = rfRsData;
        opB = rfRtData;
        if (bus.wb_en && (bus.wb_addr != '0)) begin
            if (bus.wb_addr == bus.rs) opA = bus.wb_data;
            if ((bus.wb_addr == bus.rt) && (sel_b_e'(bus.sel_b) == SELB_REG)) opB = bus.wb_data;
        end
    end
`else
    // No forwarding: software keeps producer and consumer far enough apart
    always_comb begin
        opA = rfRsData;
        opB = rfRtData;
    end
`endif

    // Choose the second ALU operand source
    always_comb begin
        in2Sel = '0;
        case (sel_b_e'(bus.sel_b))
            SELB_REG:   in2Sel = opB;
            SELB_SEXT:  in2Sel = extendImm(bus.imm16, 1'b1);
            SELB_ZEXT:  in2Sel = extendImm(bus.imm16, 1'b0);
            SELB_SHAMT: in2Sel = {27'd0, bus.shamt};
            default:    in2Sel = '0;
        endcase
    end

    // Next state: flush wins, then accept, then consume; data moves only on accept
    always_comb begin
        outValid_d = outValid_q;
        aluIn1_d   = aluIn1_q;
        aluIn2_d   = aluIn2_q;
        aluFunc_d  = aluFunc_q;
        outDest_d  = outDest_q;
        outWe_d    = outWe_q;
        if (bus.flush) begin
            outValid_d = 1'b0;
        end else if (accept) begin
            outValid_d = 1'b1;
            aluIn1_d   = opA;
            aluIn2_d   = in2Sel;
            aluFunc_d  = alu_func_e'(bus.func);
            outDest_d  = bus.dest;
            outWe_d    = bus.we;
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Pipeline register, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            aluIn1_q   <= '0;
            aluIn2_q   <= '0;
            aluFunc_q  <= ALU_SLL;
            outDest_q  <= '0;
            outWe_q    <= 1'b0;
        end else begin
            outValid_q <= outValid_d;
            aluIn1_q   <= aluIn1_d;
            aluIn2_q   <= aluIn2_d;
            aluFunc_q  <= aluFunc_d;
            outDest_q  <= outDest_d;
            outWe_q    <= outWe_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.alu_in1   = aluIn1_q;
    assign bus.alu_in2   = aluIn2_q;
    assign bus.alu_func  = aluFunc_q;
    assign bus.out_dest  = outDest_q;
    assign bus.out_we    = outWe_q;

endmodule
